uart_receiver: RTL and testbench
================================

# uart_receiver

Serial receive stage of the UART controller: the block at the far end of the transmitter's TX line. It samples the RX line with the shared 16x oversampling baud tick, reassembles 5–8 bit frames (optional parity, 1–2 stop bits), flags parity, framing and overrun errors, and detects the low-line configuration request. Its output is a single-entry data register with a valid/ack handshake, feeding the RX FIFO.

## Interface

Parameters:
- SYNC_STAGES, 2, flip-flops in the RX input synchronizer (≥2)
- CFG_COUNT, 100000, clk cycles the line must stay low after a break for a configuration request

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  reset; one clock domain; asynchronous, active-low
- enable_i  input  1  allows new start-bit detection; a frame in progress always completes
- ov_baud_rt_i  input  1  one-cycle tick, 16 per bit time
- rx_i  input  1  serial line, idle high, asynchronous
- data_width_i  input  2  00=5, 01=6, 10=7, 11=8 data bits
- parity_mode_i  input  2  bit1=1: no parity; bit0: 0 even, 1 odd
- stop_bits_number_i  input  2  01: two stop bits; any other value: one
- rx_ack_i  input  1  consumer takes rx_data_o; clears rx_valid_o
- rx_data_o  output  8  received data, right-aligned, unused upper bits 0
- rx_valid_o  output  1  rx_data_o holds an unconsumed frame
- parity_err_o  output  1  parity status of the frame in rx_data_o
- frame_err_o  output  1  stop-bit status of the frame in rx_data_o
- overrun_o  output  1  one-cycle pulse: completed frame dropped
- config_req_o  output  1  one-cycle pulse: configuration request detected
- rx_idle_o  output  1  FSM in RX_IDLE

## Operation

- Reset: all outputs 0 except rx_idle_o=1; synchronizer flops preset to 1; FSM to RX_IDLE; counters cleared. Assertion mid-frame aborts the frame immediately.
- Configuration, sampled on every tick: data_width_i, parity_mode_i, stop_bits_number_i. They must be held stable during a frame.
- All logic uses the synchronized line rx_s.
- RX_IDLE:
  - If rx_s=0, enable_i=1 and rx_valid_o is don't-care: clear the tick counter and go to RX_START.
- RX_START:
  - Counts ticks. At the 8th tick (mid start bit), if rx_s=1 it is a false start: return to RX_IDLE, no output.
  - Otherwise reset the counter and go to RX_DATA.
- RX_DATA:
  - Sample on every 16th tick (mid-bit), LSB first, shifting right into bit 7 of the shift register.
  - After width bits, go to RX_PARITY, or to RX_STOP when parity_mode_i[1]=1.
- RX_PARITY:
  - Sample at mid-bit. The error is sample != (XOR of data bits) ^ parity_mode_i[0].
- RX_STOP:
  - Sample each stop bit at mid-bit; any 0 sets the frame error. With two stop bits, both are checked.
  - After the last stop-bit sample, complete the frame:
    - rx_data_o = shift >> (8−width).
    - parity_err_o and frame_err_o are loaded.
  - Break: data bits all 0, parity (if any) 0 and stop 0. Load the frame with frame_err_o=1, then go to RX_BREAK. Otherwise go to RX_IDLE.
- RX_BREAK:
  - Count clk cycles while rx_s=0.
  - When the count reaches CFG_COUNT, pulse config_req_o once and stay in RX_BREAK.
  - rx_s=1: clear the count and go to RX_IDLE.
- Handshake:
  - On completion with rx_valid_o=0: load the output register and set rx_valid_o=1.
  - On completion with rx_valid_o=1 and no rx_ack_i: drop the new frame, keep the old data and error flags, and pulse overrun_o.
  - rx_ack_i with no completion in the same cycle: rx_valid_o=0 next cycle. Data and error flags keep their values.
  - rx_ack_i and completion in the same cycle: load the new frame, rx_valid_o stays 1, no overrun.
  - rx_ack_i while rx_valid_o=0: ignored.

## Timing

- Input latency is SYNC_STAGES cycles from rx_i to rx_s.
- Mid-bit sampling happens on tick 8 of the start bit, then every 16 ticks.
- rx_valid_o, rx_data_o and the error flags update in the clk cycle after the last stop-bit sample tick.
- overrun_o and config_req_o are registered and high for exactly one cycle.
- rx_idle_o is combinational from the state register.
- Counter widths:
  - Tick counter: 4 bits, wraps 15→0.
  - Bit counter: 3 bits.
  - Break counter: $clog2(CFG_COUNT+1) bits, saturating at CFG_COUNT.

## Test plan

- **8N1 frame:** 8 bits, no parity, 1 stop, byte 0xA5 driven at 16 ticks/bit → rx_valid_o=1 with rx_data_o=0xA5, parity_err_o=0, frame_err_o=0. rx_ack_i → rx_valid_o=0 next cycle.
- **5E2 frame with parity error:** 5 bits, even parity, 2 stop, data 0x13 with parity bit 0 (correct value is 1) → rx_data_o=0x13, parity_err_o=1. Repeat with parity bit 1 → parity_err_o=0.
- **False start and framing:**
  - A 4-tick low glitch → no frame, FSM back in RX_IDLE.
  - 0x55 sent with stop bit 0 → frame_err_o=1.
- **Overrun:**
  - Receive 0x11, then 0x22 without ack → rx_data_o stays 0x11 and overrun_o pulses once.
  - Ack in the same cycle as 0x33 completes → rx_data_o=0x33, rx_valid_o stays 1, no overrun pulse.
- **Configuration request:** CFG_COUNT=50, line held low for one frame time plus 60 cycles → frame 0x00 with frame_err_o=1, config_req_o pulses exactly once, FSM returns to RX_IDLE after the line goes high.
- **Reset mid-frame:** rst_n_i low during RX_DATA → outputs 0 and rx_idle_o=1 asynchronously. A following frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receive stage: synchronizes the RX line, samples it at mid-bit with a 16x baud tick,
// rebuilds 5-8 bit frames with parity/stop checking and hands them out through a valid/ack register.
module uart_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CFG_COUNT   = 100000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic       ov_baud_rt_i,
    input  logic       rx_i,
    input  logic [1:0] data_width_i,
    input  logic [1:0] parity_mode_i,
    input  logic [1:0] stop_bits_number_i,
    input  logic       rx_ack_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       config_req_o,
    output logic       rx_idle_o
);

    // state     | meaning
    // RX_IDLE   | line idle, waiting for a falling edge
    // RX_START  | qualifying the start bit at its middle
    // RX_DATA   | sampling data bits, LSB first
    // RX_PARITY | sampling the parity bit
    // RX_STOP   | sampling one or two stop bits, then completing the frame
    // RX_BREAK  | line held low after a break frame, timing a config request
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } state_t;

    localparam int             BW      = $clog2(CFG_COUNT + 1);
    localparam logic [BW-1:0]  BRK_MAX = BW'(CFG_COUNT);

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             tick_cnt_q;
    logic [2:0]             bit_cnt_q;
    logic                   stop_cnt_q;
    logic [7:0]             shift_q;
    logic                   par_acc_q;
    logic                   any_one_q;
    logic                   perr_acc_q;
    logic                   ferr_acc_q;
    logic [BW-1:0]          brk_cnt_q;
    logic [7:0]             rx_data_q;
    logic                   rx_valid_q;
    logic                   parity_err_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   config_req_q;

    logic       rx_s;
    logic       mid_bit_d;
    logic       last_data_d;
    logic       two_stop_d;
    logic       complete_d;
    logic       load_d;
    logic       frame_ferr_d;
    logic       is_break_d;
    logic [7:0] frame_data_d;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        mid_bit_d    = ov_baud_rt_i && (tick_cnt_q == 4'd15);
        last_data_d  = (bit_cnt_q == ({1'b0, data_width_i} + 3'd4));
        two_stop_d   = (stop_bits_number_i == 2'b01);
        complete_d   = (state_q == RX_STOP) && mid_bit_d && (!two_stop_d || stop_cnt_q);
        load_d       = complete_d && (!rx_valid_q || rx_ack_i);
        frame_ferr_d = ferr_acc_q | ~rx_s;
        // Break: every sampled bit of the frame, including the final stop, was low.
        is_break_d   = !any_one_q && !rx_s;
        frame_data_d = shift_q >> (2'd3 - data_width_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= RX_IDLE;
            sync_q       <= '1;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            shift_q      <= '0;
            par_acc_q    <= 1'b0;
            any_one_q    <= 1'b0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            brk_cnt_q    <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            config_req_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], rx_i};
            overrun_q    <= 1'b0;
            config_req_q <= 1'b0;

            if (load_d) begin
                rx_data_q    <= frame_data_d;
                parity_err_q <= perr_acc_q;
                frame_err_q  <= frame_ferr_d;
                rx_valid_q   <= 1'b1;
            end else if (complete_d) begin
                overrun_q <= 1'b1;
            end else if (rx_ack_i) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                RX_IDLE: begin
                    if (!rx_s && enable_i) begin
                        tick_cnt_q <= '0;
                        state_q    <= RX_START;
                    end
                end
                RX_START: begin
                    if (ov_baud_rt_i) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd7) begin
                            tick_cnt_q <= '0;
                            if (rx_s) begin
                                state_q <= RX_IDLE;
                            end else begin
                                state_q    <= RX_DATA;
                                bit_cnt_q  <= '0;
                                stop_cnt_q <= 1'b0;
                                par_acc_q  <= 1'b0;
                                any_one_q  <= 1'b0;
                                perr_acc_q <= 1'b0;
                                ferr_acc_q <= 1'b0;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (ov_baud_rt_i) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (mid_bit_d) begin
                            shift_q   <= {rx_s, shift_q[7:1]};
                            par_acc_q <= par_acc_q ^ rx_s;
                            any_one_q <= any_one_q | rx_s;
                            if (last_data_d) begin
                                bit_cnt_q <= '0;
                                state_q   <= parity_mode_i[1] ? RX_STOP : RX_PARITY;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
                end
                RX_PARITY: begin
                    if (ov_baud_rt_i) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (mid_bit_d) begin
                            perr_acc_q <= rx_s ^ par_acc_q ^ parity_mode_i[0];
                            any_one_q  <= any_one_q | rx_s;
                            state_q    <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (ov_baud_rt_i) begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (mid_bit_d) begin
                            any_one_q <= any_one_q | rx_s;
                            if (!rx_s) begin
                                ferr_acc_q <= 1'b1;
                            end
                            if (complete_d) begin
                                brk_cnt_q <= '0;
                                state_q   <= is_break_d ? RX_BREAK : RX_IDLE;
                            end else begin
                                stop_cnt_q <= 1'b1;
                            end
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_s) begin
                        brk_cnt_q <= '0;
                        state_q   <= RX_IDLE;
                    end else if (brk_cnt_q != BRK_MAX) begin
                        brk_cnt_q <= brk_cnt_q + BW'(1);
                        if (brk_cnt_q == BRK_MAX - BW'(1)) begin
                            config_req_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;
    assign config_req_o = config_req_q;
    assign rx_idle_o    = (state_q == RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serial frames are built bit by bit against the tick, expected frames
// are queued as they are sent and compared when the receiver presents them.
module tb_uart_receiver;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       enable_i;
    logic       ov_baud_rt_i;
    logic       rx_i;
    logic [1:0] data_width_i;
    logic [1:0] parity_mode_i;
    logic [1:0] stop_bits_number_i;
    logic       rx_ack_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       config_req_o;
    logic       rx_idle_o;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   fails     = 0;
    int   ovr_cnt   = 0;
    int   cfg_cnt   = 0;

    uart_receiver #(.SYNC_STAGES(2), .CFG_COUNT(50)) dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .enable_i           (enable_i),
        .ov_baud_rt_i       (ov_baud_rt_i),
        .rx_i               (rx_i),
        .data_width_i       (data_width_i),
        .parity_mode_i      (parity_mode_i),
        .stop_bits_number_i (stop_bits_number_i),
        .rx_ack_i           (rx_ack_i),
        .rx_data_o          (rx_data_o),
        .rx_valid_o         (rx_valid_o),
        .parity_err_o       (parity_err_o),
        .frame_err_o        (frame_err_o),
        .overrun_o          (overrun_o),
        .config_req_o       (config_req_o),
        .rx_idle_o          (rx_idle_o)
    );

    always #5 clk_i = ~clk_i;

    // One tick every 4 clocks, changed on the falling edge.
    initial begin
        int tcnt;
        tcnt = 0;
        ov_baud_rt_i = 1'b0;
        forever begin
            @(negedge clk_i);
            tcnt = (tcnt + 1) % 4;
            ov_baud_rt_i = (tcnt == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (overrun_o)    ovr_cnt++;
            if (config_req_o) cfg_cnt++;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_perr(input logic [7:0] d, input int w, input logic par_bit,
                                      input logic odd);
        logic x;
        x = odd;
        for (int i = 0; i < w; i++) x ^= d[i];
        return par_bit != x;
    endfunction

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk_i);
            if (ov_baud_rt_i) k++;
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int w, input bit has_par,
                              input logic par_bit, input int nstop, input logic stop_val,
                              input bit hold_low, input bit ack_last,
                              output logic valid_seen, output logic [7:0] data_seen);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < w; i++) bits.push_back(d[i]);
        if (has_par) bits.push_back(par_bit);
        for (int j = 0; j < nstop; j++) bits.push_back(stop_val);
        valid_seen = 1'b0;
        data_seen  = 8'h00;
        wait_ticks(1);
        for (int b = 0; b < bits.size(); b++) begin
            rx_i = bits[b];
            if (b == bits.size() - 1) begin
                wait_ticks(7);
                if (ack_last) begin
                    repeat (3) @(posedge clk_i);
                    #1 rx_ack_i = 1'b1;
                    @(posedge clk_i);
                    #1 rx_ack_i = 1'b0;
                    valid_seen = rx_valid_o;
                    data_seen  = rx_data_o;
                end else begin
                    wait_ticks(1);
                end
                if (hold_low) begin
                    wait_ticks(8);
                end else begin
                    wait_ticks(1);
                    rx_i = 1'b1;
                    wait_ticks(7);
                end
            end else begin
                wait_ticks(16);
            end
        end
    endtask

    task automatic check_rx(input string name, input bit do_ack);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk_i);
        while (!rx_valid_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        tests_run++;
        if (rx_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL %s_valid: got %b expected 1 (timeout)", name, rx_valid_o);
            return;
        end
        tests_run++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s_queue: got frame %h expected none", name, rx_data_o);
            return;
        end
        e = sb.pop_front();
        tests_run++;
        if (rx_data_o !== e.data) begin
            fails++;
            $display("FAIL %s_data: got %h expected %h", name, rx_data_o, e.data);
        end
        tests_run++;
        if (parity_err_o !== e.perr) begin
            fails++;
            $display("FAIL %s_perr: got %b expected %b", name, parity_err_o, e.perr);
        end
        tests_run++;
        if (frame_err_o !== e.ferr) begin
            fails++;
            $display("FAIL %s_ferr: got %b expected %b", name, frame_err_o, e.ferr);
        end
        if (do_ack) begin
            rx_ack_i = 1'b1;
            @(negedge clk_i);
            rx_ack_i = 1'b0;
            tests_run++;
            if (rx_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL %s_ack_clear: got %b expected 0", name, rx_valid_o);
            end
            tests_run++;
            if (rx_data_o !== e.data) begin
                fails++;
                $display("FAIL %s_ack_hold: got %h expected %h", name, rx_data_o, e.data);
            end
        end
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic [1:0] p, input logic [1:0] s);
        data_width_i       = w;
        parity_mode_i      = p;
        stop_bits_number_i = s;
    endtask

    task automatic check_quiet(input string name);
        tests_run++;
        if (rx_valid_o !== 1'b0 || rx_data_o !== 8'h00 || parity_err_o !== 1'b0 ||
            frame_err_o !== 1'b0 || overrun_o !== 1'b0 || config_req_o !== 1'b0) begin
            fails++;
            $display("FAIL %s_outs: got v=%b d=%h pe=%b fe=%b ov=%b cr=%b expected all 0", name,
                     rx_valid_o, rx_data_o, parity_err_o, frame_err_o, overrun_o, config_req_o);
        end
        tests_run++;
        if (rx_idle_o !== 1'b1) begin
            fails++;
            $display("FAIL %s_idle: got %b expected 1", name, rx_idle_o);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_quiet("reset_hold");
        rst_n_i = 1'b1;
        repeat (10) @(negedge clk_i);
        check_quiet("reset_release");
    endtask

    task automatic test_8n1();
        logic       v;
        logic [7:0] d;
        set_cfg(2'b11, 2'b10, 2'b00);
        sb.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, v, d);
        check_rx("8n1_a5", 1'b1);
        sb.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, v, d);
        check_rx("8n1_5a", 1'b1);
    endtask

    task automatic test_5e2();
        logic       v;
        logic [7:0] d;
        set_cfg(2'b00, 2'b00, 2'b01);
        sb.push_back('{data: 8'h13, perr: exp_perr(8'h13, 5, 1'b0, 1'b0), ferr: 1'b0});
        send_frame(8'h13, 5, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, v, d);
        check_rx("5e2_bad", 1'b1);
        sb.push_back('{data: 8'h13, perr: exp_perr(8'h13, 5, 1'b1, 1'b0), ferr: 1'b0});
        send_frame(8'h13, 5, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0, v, d);
        check_rx("5e2_good", 1'b1);
        set_cfg(2'b10, 2'b01, 2'b00);
        sb.push_back('{data: 8'h4B, perr: exp_perr(8'h4B, 7, 1'b1, 1'b1), ferr: 1'b0});
        send_frame(8'h4B, 7, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, v, d);
        check_rx("7o1", 1'b1);
    endtask

    task automatic test_false_start();
        set_cfg(2'b11, 2'b10, 2'b00);
        wait_ticks(1);
        rx_i = 1'b0;
        wait_ticks(4);
        rx_i = 1'b1;
        wait_ticks(40);
        tests_run++;
        if (rx_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL glitch_valid: got %b expected 0", rx_valid_o);
        end
        tests_run++;
        if (rx_idle_o !== 1'b1) begin
            fails++;
            $display("FAIL glitch_idle: got %b expected 1", rx_idle_o);
        end
    endtask

    task automatic test_framing();
        logic       v;
        logic [7:0] d;
        set_cfg(2'b11, 2'b10, 2'b00);
        sb.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b1});
        send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, v, d);
        check_rx("frame_err", 1'b1);
    endtask

    task automatic test_overrun();
        logic       v;
        logic [7:0] d;
        int         o0;
        set_cfg(2'b11, 2'b10, 2'b00);
        sb.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, v, d);
        o0 = ovr_cnt;
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, v, d);
        tests_run++;
        if (ovr_cnt !== o0 + 1) begin
            fails++;
            $display("FAIL overrun_pulse: got %0d pulses expected 1", ovr_cnt - o0);
        end
        check_rx("overrun_keep", 1'b0);
        o0 = ovr_cnt;
        sb.push_back('{data: 8'h33, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h33, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, v, d);
        tests_run++;
        if (v !== 1'b1 || d !== 8'h33) begin
            fails++;
            $display("FAIL ack_same_cycle: got v=%b d=%h expected v=1 d=33", v, d);
        end
        tests_run++;
        if (ovr_cnt !== o0) begin
            fails++;
            $display("FAIL ack_same_no_overrun: got %0d pulses expected 0", ovr_cnt - o0);
        end
        check_rx("ack_same", 1'b1);
    endtask

    task automatic test_config_req();
        logic       v;
        logic [7:0] d;
        int         c0;
        set_cfg(2'b11, 2'b10, 2'b00);
        c0 = cfg_cnt;
        sb.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
        send_frame(8'h00, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, v, d);
        repeat (60) @(negedge clk_i);
        check_rx("break", 1'b1);
        tests_run++;
        if (cfg_cnt !== c0 + 1) begin
            fails++;
            $display("FAIL config_pulse: got %0d pulses expected 1", cfg_cnt - c0);
        end
        tests_run++;
        if (rx_idle_o !== 1'b0) begin
            fails++;
            $display("FAIL break_not_idle: got %b expected 0", rx_idle_o);
        end
        rx_i = 1'b1;
        repeat (6) @(negedge clk_i);
        tests_run++;
        if (rx_idle_o !== 1'b1) begin
            fails++;
            $display("FAIL break_exit_idle: got %b expected 1", rx_idle_o);
        end
        tests_run++;
        if (cfg_cnt !== c0 + 1) begin
            fails++;
            $display("FAIL config_once: got %0d pulses expected 1", cfg_cnt - c0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic       v;
        logic [7:0] d;
        set_cfg(2'b11, 2'b10, 2'b00);
        sb.push_back('{data: 8'h77, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h77, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, v, d);
        check_rx("pre_reset", 1'b0);
        wait_ticks(1);
        rx_i = 1'b0;
        wait_ticks(16);
        rx_i = 1'b1;
        wait_ticks(10);
        #2 rst_n_i = 1'b0;
        #1;
        check_quiet("reset_mid");
        rx_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        sb.delete();
        sb.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, v, d);
        check_rx("after_reset", 1'b1);
    endtask

    initial begin
        rst_n_i  = 1'b0;
        enable_i = 1'b1;
        rx_i     = 1'b1;
        rx_ack_i = 1'b0;
        set_cfg(2'b11, 2'b10, 2'b00);
        test_reset();
        test_8n1();
        test_5e2();
        test_false_start();
        test_framing();
        test_overrun();
        test_config_req();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
